// File: rtl/movebit_pkg.sv
// rtl/movebit_pkg.sv - shared types and imm16 field layout for the bit-field move sequencer
package movebit_pkg;

  localparam int WIDTH = 32;
  localparam int POSW  = 5;

  // imm16 field offsets
  localparam int SRC_LSB = 0;
  localparam int DST_LSB = 5;
  localparam int LEN_LSB = 10;
  localparam int CLR_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mb_state_t;

endpackage

// File: rtl/movebit_seq.sv
// rtl/movebit_seq.sv - one-bit-per-cycle bit-field move sequencer
module movebit_seq
  import movebit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  read1,
  input  logic [15:0]       imm16,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  moveout
);

  mb_state_t         state_q, state_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic [WIDTH-1:0]  w_q, w_d;
  logic [WIDTH-1:0]  moveout_q, moveout_d;
  logic [POSW-1:0]   src_q, src_d;
  logic [POSW-1:0]   dst_q, dst_d;
  logic [POSW-1:0]   lenm1_q, lenm1_d;   // field length minus one
  logic [POSW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Positions are one bit wider than the counter so the "reached bit 31" test is exact
  logic [POSW:0]     src_pos;
  logic [POSW:0]     dst_pos;
  logic              last_step;

  assign src_pos   = {1'b0, src_q} + {1'b0, idx_q};
  assign dst_pos   = {1'b0, dst_q} + {1'b0, idx_q};
  assign last_step = (idx_q == lenm1_q) ||
                     (src_pos == (POSW+1)'(WIDTH-1)) ||
                     (dst_pos == (POSW+1)'(WIDTH-1));

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    w_d       = w_q;
    moveout_d = moveout_q;
    src_d     = src_q;
    dst_d     = dst_q;
    lenm1_d   = lenm1_q;
    idx_d     = idx_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          op_d    = read1;
          w_d     = imm16[CLR_BIT] ? '0 : read1;
          src_d   = imm16[SRC_LSB +: POSW];
          dst_d   = imm16[DST_LSB +: POSW];
          lenm1_d = imm16[LEN_LSB +: POSW];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // Reads come from the latched operand, so overlapping fields are safe
          w_d[dst_pos[POSW-1:0]] = op_q[src_pos[POSW-1:0]];
          if (last_step) begin
            moveout_d = w_d;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            busy_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and working registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      w_q       <= '0;
      moveout_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      lenm1_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      w_q       <= w_d;
      moveout_q <= moveout_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      lenm1_q   <= lenm1_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign moveout = moveout_q;

endmodule

// File: tb/tb_movebit_seq.sv
// tb/tb_movebit_seq.sv - directed self-checking bench for movebit_seq
module tb_movebit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] read1;
  logic [15:0] imm16;
  logic        busy;
  logic        done;
  logic [31:0] moveout;

  int n_checks;
  int n_errors;

  movebit_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .read1   (read1),
    .imm16   (imm16),
    .busy    (busy),
    .done    (done),
    .moveout (moveout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation and measure busy cycles; optionally pulse start again in RUN
  task automatic run_op(input string tag, input logic [31:0] r, input logic [15:0] imm,
                        input int exp_n, input logic [31:0] exp_out, input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1;
    read1 = r;
    imm16 = imm;
    @(negedge clk);
    start = 1'b0;
    read1 = 32'h0;
    imm16 = 16'h0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (poke && n == 2) begin
        start = 1'b1;
        read1 = 32'hDEAD_BEEF;
        imm16 = 16'h7C00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_moveout"}, moveout, exp_out);
    @(negedge clk);
    check({tag, "_done_clear"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    read1 = 32'h0;
    imm16 = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_moveout", moveout, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    read1 = 32'h0FFF_FFFF;
    imm16 = 16'h0F80;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_busy", {31'b0, busy}, 32'd0);

    // Abort in RUN cycle 2 from moveout=0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_run_c1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("abort_run_c2_busy", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_moveout", moveout, 32'h0);
    @(negedge clk);
    check("abort_no_late_done", {31'b0, done}, 32'd0);
    check("abort_no_late_busy", {31'b0, busy}, 32'd0);

    // Basic move with a stray start during RUN
    run_op("basic", 32'h0FFF_FFFF, 16'h0F80, 4, 32'hFFFF_FFFF, 1'b1);
    run_op("clear", 32'hA000_0000, 16'h8C1C, 4, 32'h0000_000A, 1'b0);
    run_op("srcclip", 32'hC000_0000, 16'h1C1E, 2, 32'hC000_0003, 1'b0);
    run_op("full", 32'h1234_5678, 16'h7C00, 32, 32'h1234_5678, 1'b0);
    // Destination clip: src=0, dst=30, len=8 -> two steps
    run_op("dstclip", 32'h0000_0002, 16'h1FC0, 2, 32'h8000_0002, 1'b0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1;
    read1 = 32'h0FFF_FFFF;
    imm16 = 16'h0F80;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("prereset_busy", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_done", {31'b0, done}, 32'd0);
    check("async_moveout", moveout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset", 32'h0FFF_FFFF, 16'h0F80, 4, 32'hFFFF_FFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
